// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory port and decode stream of the fetch sequencer
interface fetch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and prefetch FIFO feeding decode, with start/halt/redirect control
// Optional FETCH_CTRL_PERF_EN adds saturating fetch_cnt/flush_cnt counters.
module fetch_ctrl #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_ctrl_if.master      bus,
    output logic              busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop, fetch;

    assign bus.mem_addr  = pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = instr_mem[rd_ptr];
    assign bus.out_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        pop       = 1'b0;
        fetch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !halt_req) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (halt_req) state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (start && !halt_req) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A redirect freezes the FIFO for its cycle: nothing enters or leaves.
        pop   = bus.out_valid && bus.out_ready && !redirect;
        fetch = (state == S_RUN) && !redirect &&
                ((count < CNT_W'(FIFO_DEPTH)) || pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect) begin
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                instr_mem[wr_ptr] <= bus.mem_rdata;
                pc_mem[wr_ptr]    <= pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                pc                <= pc + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt} + 33'(count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fetch && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect) begin
                flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
            end
        end
    end
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the instruction memory and the decode stage.
- Owns the program counter and drives the word address into the instruction memory.
- Captures each returned instruction, tagged with its PC, into a small prefetch FIFO and hands it to decode over a valid/ready handshake.
- Handles start/halt control and branch/jump redirects, flushing stale prefetched words on a redirect.

Parameters:
- ADDR_W, 10, word-address width into instruction memory (equals `logDepthMem).
- DATA_W, 32, instruction width (equals `width).
- FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse: leave IDLE/HALTED and begin fetching.
- halt_req  in  1  single-cycle pulse: stop issuing new fetches.
- redirect  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  target word address, sampled when redirect=1.
- mem_addr  out  ADDR_W  address to the instruction memory; equals the pc register.
- mem_rdata  in  DATA_W  instruction from memory; combinational, valid in the same cycle as mem_addr.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  DATA_W  instruction at the FIFO head.
- out_pc  out  ADDR_W  PC of out_instr.
- busy  out  1  1 in RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, FIFO empty, out_valid=0, busy=0.
  - out_instr and out_pc are 0.
  - mem_addr=RESET_PC.
  - Reset mid-operation discards all FIFO contents immediately.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on start.
  - RUN -> HALTED on halt_req.
  - HALTED -> RUN on start.
  - start while in RUN: ignored.
  - halt_req while in IDLE or HALTED: ignored.
  - halt_req and start in the same cycle: halt_req wins.
- Pop: pop = out_valid & out_ready.
- Fetch: fetch = (state==RUN) & ~redirect & (count < FIFO_DEPTH, or count == FIFO_DEPTH with pop this cycle).
- On fetch:
  - push {mem_rdata, pc};
  - pc <= pc+1, wrapping modulo 2^ADDR_W (all-ones wraps to 0, no flag).
  - Push and pop in the same cycle keep count unchanged.
- Redirect (any state):
  - pc <= redirect_pc; FIFO flushed (count=0); no push or pop takes effect that cycle.
  - out_valid is 0 in the following cycle.
  - In RUN, the first word from the target is pushed in the cycle after the redirect and visible on out_valid one cycle later.
  - A redirect in IDLE/HALTED only loads pc; the state is unchanged.
  - A redirect in the same cycle as halt_req applies both: pc loaded, FIFO flushed, state -> HALTED.
- Latency: with out_ready=1 in RUN, one instruction per cycle. The first out_valid appears 1 cycle after the first fetch cycle, i.e. 2 cycles after the start pulse.
- HALTED/IDLE:
  - no fetches;
  - FIFO contents remain poppable until drained;
  - pc holds the next unfetched address.
- Full: when count==FIFO_DEPTH and there is no pop, pc holds and mem_addr is stable.
- Empty: out_valid=0; out_instr/out_pc hold their last values (don't-care to decode).

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, add two outputs:
  - fetch_cnt (32 b): increments on every fetch.
  - flush_cnt (32 b): increments by the number of valid entries discarded on each redirect.
  - Both reset to 0, saturate at all-ones, and are cleared by rst only.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, start at cycle 3, memory word[i]=0x1000_0000+i, out_ready=1 -> out_valid rises at cycle 5 with pc=0, instr 0x10000000; then pc 1, 2, 3 on consecutive cycles.
- out_ready=0 after start -> FIFO fills with pc 0 and 1, mem_addr holds at 2, out_valid stays 1. Raising out_ready -> pc 0, 1, 2 delivered with no gaps or duplicates.
- Redirect to 0x080 while the FIFO holds pc 4 and 5 -> out_valid=0 the next cycle; next delivered out_pc=0x080; pc 4 and 5 never delivered. Perf build: flush_cnt=2.
- halt_req with 2 entries queued -> both entries still delivered, then out_valid=0, busy=0, mem_addr frozen at the next address. start -> resumes from that address.
- RESET_PC=0x3FE, ADDR_W=10, start -> delivered pc sequence 0x3FE, 0x3FF, 0x000.
- rst asserted mid-RUN with a full FIFO -> out_valid=0 and mem_addr=RESET_PC immediately (asynchronously). After release, state=IDLE and no fetch occurs until start.
